// File: rtl/mem_responder_pkg.sv
// Memory map shared by the responder and its bench-facing docs: MMIO base,
// register offsets, STATUS/TCTRL bit positions and the bus-error read word.
package mem_responder_pkg;

  localparam logic [31:0] MMIO_BASE    = 32'hF000_0000;
  localparam logic [31:0] OFF_TXDATA   = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS   = 32'h0000_0004;
  localparam logic [31:0] OFF_CYCLES   = 32'h0000_0008;
  localparam logic [31:0] OFF_TCMP     = 32'h0000_000C;
  localparam logic [31:0] OFF_TCTRL    = 32'h0000_0010;

  localparam int unsigned STATUS_FULL    = 0;
  localparam int unsigned STATUS_EMPTY   = 1;
  localparam int unsigned STATUS_OVF     = 2;
  localparam int unsigned STATUS_CNT_LSB = 8;

  localparam int unsigned TCTRL_EN   = 0;
  localparam int unsigned TCTRL_PEND = 1;

  localparam logic [31:0] BUS_ERR_WORD = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    REG_TXDATA = 3'd0,
    REG_STATUS = 3'd1,
    REG_CYCLES = 3'd2,
    REG_TCMP   = 3'd3,
    REG_TCTRL  = 3'd4,
    REG_NONE   = 3'd7
  } mmio_reg_e;

  // Byte-lane bits are ignored, so compare on the word-aligned address.
  function automatic mmio_reg_e mmio_decode(input logic [31:0] addr);
    logic [31:0] w;
    w = {addr[31:2], 2'b00};
    if (w == MMIO_BASE + OFF_TXDATA) return REG_TXDATA;
    if (w == MMIO_BASE + OFF_STATUS) return REG_STATUS;
    if (w == MMIO_BASE + OFF_CYCLES) return REG_CYCLES;
    if (w == MMIO_BASE + OFF_TCMP)   return REG_TCMP;
    if (w == MMIO_BASE + OFF_TCTRL)  return REG_TCTRL;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/mem_responder_sync_fifo.sv
// Single-clock FIFO with 1-cycle push/pop; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle. Async active-low reset.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop  = pop && (cnt != '0);
    do_push = push && ((cnt != FULL_CNT) || do_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/mem_responder.sv
// CPU memory-bus responder: word RAM plus MMIO page (TX FIFO, cycle counter,
// compare timer). Optional MEM_BUS_ERR_EN: unmapped reads return 0xDEAD_BEEF and pulse bus_err.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned RAM_AW     = 10,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data_out,
  input  logic        data_rw,
  output logic [31:0] data_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq,
  output logic        bus_err
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

`ifdef MEM_BUS_ERR_EN
  localparam logic [31:0] UNMAPPED_WORD = BUS_ERR_WORD;
`else
  localparam logic [31:0] UNMAPPED_WORD = '0;
`endif

  logic [31:0]       ram [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  mmio_reg_e         sel;
  logic              is_ram;
  logic              unmapped;
  logic              wr_txdata, wr_status, wr_cycles, wr_tcmp, wr_tctrl;

  always_comb begin
    sel       = mmio_decode(address);
    is_ram    = (address[31:RAM_AW+2] == '0);
    unmapped  = !is_ram && (sel == REG_NONE);
    ram_idx   = address[RAM_AW+1:2];
    wr_txdata = data_rw && (sel == REG_TXDATA);
    wr_status = data_rw && (sel == REG_STATUS);
    wr_cycles = data_rw && (sel == REG_CYCLES);
    wr_tcmp   = data_rw && (sel == REG_TCMP);
    wr_tctrl  = data_rw && (sel == REG_TCTRL);
  end

  always_ff @(posedge clk) begin
    if (data_rw && is_ram) ram[ram_idx] <= data_out;
  end

  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_pop;
  logic             overflow;

  assign tx_valid = !fifo_empty;
  assign fifo_pop = tx_valid && tx_ready;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (data_out[7:0]),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A full-FIFO push only drops the byte when no pop frees a slot that cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (wr_status && data_out[STATUS_OVF]) begin
      overflow <= 1'b0;
    end else if (wr_txdata && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end
  end

  logic [31:0] cycles;
  logic [31:0] tcmp;
  logic        tmr_en;
  logic        tmr_pend;
  logic        tmr_match;

  assign tmr_match = tmr_en && (cycles == tcmp) && !wr_cycles;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles   <= '0;
      tcmp     <= '1;
      tmr_en   <= 1'b0;
      tmr_pend <= 1'b0;
    end else begin
      cycles <= wr_cycles ? data_out : cycles + 32'd1;
      if (wr_tcmp)  tcmp   <= data_out;
      if (wr_tctrl) tmr_en <= data_out[TCTRL_EN];
      if (tmr_match)
        tmr_pend <= 1'b1;
      else if (wr_tctrl && data_out[TCTRL_PEND])
        tmr_pend <= 1'b0;
    end
  end

  assign irq = tmr_pend;

`ifdef MEM_BUS_ERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bus_err <= 1'b0;
    else        bus_err <= unmapped;
  end
`else
  assign bus_err = 1'b0;
`endif

  always_comb begin
    data_in = '0;
    if (is_ram) begin
      data_in = ram[ram_idx];
    end else if (unmapped) begin
      data_in = UNMAPPED_WORD;
    end else begin
      case (sel)
        REG_STATUS: begin
          data_in[STATUS_FULL]             = fifo_full;
          data_in[STATUS_EMPTY]            = fifo_empty;
          data_in[STATUS_OVF]              = overflow;
          data_in[STATUS_CNT_LSB +: 8]     = 8'(fifo_count);
        end
        REG_CYCLES: data_in = cycles;
        REG_TCMP:   data_in = tcmp;
        REG_TCTRL: begin
          data_in[TCTRL_EN]   = tmr_en;
          data_in[TCTRL_PEND] = tmr_pend;
        end
        default:    data_in = '0;
      endcase
    end
  end

endmodule
